// File: rtl/sram_access_sequencer_if.sv
// SRAM_controller-side port of the sequencer: one address/data/write-enable bundle.
// The sequencer drives it as master and SRAM_controller consumes it as slave.
interface sram_access_sequencer_if;
    logic [17:0] sram_address;
    logic [15:0] sram_write_data;
    logic        sram_we_n;

    modport master (output sram_address, output sram_write_data, output sram_we_n);
    modport slave  (input  sram_address, input  sram_write_data, input  sram_we_n);
endinterface

// File: rtl/sram_access_sequencer.sv
// Top-level UART -> M1 -> VGA sequencer and single-port SRAM arbiter.
// Ownerless guard cycles at each hand-over drain SRAM read latency.
module sram_access_sequencer #(
    parameter int unsigned        TIMER_W      = 26,
    parameter logic [TIMER_W-1:0] UART_TIMEOUT = 26'd49999999,
    parameter int unsigned        GUARD_CYCLES = 2
) (
    input  logic                        CLOCK_50_I,
    input  logic                        resetn,
    input  logic                        UART_RX_I,
    input  logic [17:0]                 uart_sram_address,
    input  logic [15:0]                 uart_sram_write_data,
    input  logic                        uart_sram_we_n,
    output logic                        uart_rx_initialize,
    output logic                        uart_rx_enable,
    output logic                        m1_start,
    input  logic                        m1_done,
    input  logic [17:0]                 m1_sram_address,
    input  logic [15:0]                 m1_sram_write_data,
    input  logic                        m1_sram_we_n,
    input  logic [17:0]                 vga_sram_address,
    output logic                        vga_enable,
    sram_access_sequencer_if.master     sram_bus,
    output logic [1:0]                  owner,
    output logic                        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UART_RX,
        S_GUARD_A,
        S_M1_START,
        S_M1_RUN,
        S_GUARD_B,
        S_DISPLAY
    } state_t;

    typedef enum logic [1:0] {
        OWN_VGA  = 2'd0,
        OWN_UART = 2'd1,
        OWN_M1   = 2'd2,
        OWN_NONE = 2'd3
    } owner_t;

    localparam logic [1:0] GUARD_LAST = 2'(GUARD_CYCLES - 1);

    state_t             state_q;
    owner_t             owner_q;
    logic               vga_enable_q;
    logic               uart_init_q;
    logic               uart_enable_q;
    logic               m1_start_q;
    logic               busy_q;
    logic [TIMER_W-1:0] timer_q;
    logic [1:0]         guard_q;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            owner_q       <= OWN_VGA;
            vga_enable_q  <= 1'b1;
            uart_init_q   <= 1'b0;
            uart_enable_q <= 1'b0;
            m1_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timer_q       <= '0;
            guard_q       <= '0;
        end else begin
            uart_init_q   <= 1'b0;
            uart_enable_q <= 1'b0;
            m1_start_q    <= 1'b0;

            case (state_q)
                S_IDLE, S_DISPLAY: begin
                    owner_q      <= OWN_VGA;
                    vga_enable_q <= 1'b1;
                    if (!UART_RX_I) begin
                        uart_init_q  <= 1'b1;
                        timer_q      <= '0;
                        vga_enable_q <= 1'b0;
                        owner_q      <= OWN_UART;
                        busy_q       <= 1'b1;
                        state_q      <= S_UART_RX;
                    end
                end

                S_UART_RX: begin
                    uart_enable_q <= uart_init_q;
                    // A write on the expiry cycle takes priority and restarts the idle count.
                    if (!uart_sram_we_n) begin
                        timer_q <= '0;
                    end else if (timer_q == UART_TIMEOUT) begin
                        timer_q <= '0;
                        owner_q <= OWN_NONE;
                        guard_q <= '0;
                        state_q <= S_GUARD_A;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_GUARD_A: begin
                    if (guard_q == GUARD_LAST) begin
                        owner_q    <= OWN_M1;
                        m1_start_q <= 1'b1;
                        state_q    <= S_M1_START;
                    end else begin
                        guard_q <= guard_q + 1'b1;
                    end
                end

                S_M1_START: begin
                    state_q <= S_M1_RUN;
                end

                S_M1_RUN: begin
                    if (m1_done) begin
                        owner_q <= OWN_NONE;
                        guard_q <= '0;
                        state_q <= S_GUARD_B;
                    end
                end

                S_GUARD_B: begin
                    if (guard_q == GUARD_LAST) begin
                        owner_q      <= OWN_VGA;
                        vga_enable_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_DISPLAY;
                    end else begin
                        guard_q <= guard_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Mux is keyed only on registered owner, so reset forces a read-only port immediately.
    always_comb begin
        sram_bus.sram_address    = '0;
        sram_bus.sram_write_data = '0;
        sram_bus.sram_we_n       = 1'b1;
        unique case (owner_q)
            OWN_VGA: begin
                sram_bus.sram_address = vga_sram_address;
            end
            OWN_UART: begin
                sram_bus.sram_address    = uart_sram_address;
                sram_bus.sram_write_data = uart_sram_write_data;
                sram_bus.sram_we_n       = uart_sram_we_n;
            end
            OWN_M1: begin
                sram_bus.sram_address    = m1_sram_address;
                sram_bus.sram_write_data = m1_sram_write_data;
                sram_bus.sram_we_n       = m1_sram_we_n;
            end
            OWN_NONE: begin
                sram_bus.sram_address = '0;
            end
        endcase
    end

    assign owner              = owner_q;
    assign vga_enable         = vga_enable_q;
    assign uart_rx_initialize = uart_init_q;
    assign uart_rx_enable     = uart_enable_q;
    assign m1_start           = m1_start_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed bench for sram_access_sequencer with UART_TIMEOUT shortened to 1000.
// Inputs change and outputs are checked on the falling edge.
module tb_sram_access_sequencer;

    logic        clk;
    logic        resetn;
    logic        uart_rx;
    logic [17:0] uart_addr;
    logic [15:0] uart_data;
    logic        uart_we_n;
    logic        uart_init;
    logic        uart_en;
    logic        m1_start;
    logic        m1_done;
    logic [17:0] m1_addr;
    logic [15:0] m1_data;
    logic        m1_we_n;
    logic [17:0] vga_addr;
    logic        vga_en;
    logic [1:0]  owner;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sram_access_sequencer_if bus ();

    sram_access_sequencer #(
        .TIMER_W      (26),
        .UART_TIMEOUT (26'd1000),
        .GUARD_CYCLES (2)
    ) dut (
        .CLOCK_50_I           (clk),
        .resetn               (resetn),
        .UART_RX_I            (uart_rx),
        .uart_sram_address    (uart_addr),
        .uart_sram_write_data (uart_data),
        .uart_sram_we_n       (uart_we_n),
        .uart_rx_initialize   (uart_init),
        .uart_rx_enable       (uart_en),
        .m1_start             (m1_start),
        .m1_done              (m1_done),
        .m1_sram_address      (m1_addr),
        .m1_sram_write_data   (m1_data),
        .m1_sram_we_n         (m1_we_n),
        .vga_sram_address     (vga_addr),
        .vga_enable           (vga_en),
        .sram_bus             (bus.master),
        .owner                (owner),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        uart_rx   = 1'b1;
        uart_addr = 18'h00055;
        uart_data = 16'h1111;
        uart_we_n = 1'b1;
        m1_done   = 1'b0;
        m1_addr   = 18'h1234;
        m1_data   = 16'hBEEF;
        m1_we_n   = 1'b1;
        vga_addr  = 18'h2AAAA;

        step(2);
        check("rst_owner",    owner, 0);
        check("rst_vga_en",   vga_en, 1);
        check("rst_busy",     busy, 0);
        check("rst_init",     uart_init, 0);
        check("rst_enable",   uart_en, 0);
        check("rst_m1_start", m1_start, 0);
        check("rst_addr",     bus.sram_address, 32'h2AAAA);
        check("rst_wdata",    bus.sram_write_data, 0);
        check("rst_we_n",     bus.sram_we_n, 1);

        resetn = 1'b1;
        step(8);
        check("idle_owner", owner, 0);

        // Start bit at cycle 10
        uart_rx = 1'b0;
        step(1);
        uart_rx = 1'b1;
        check("rx_init",      uart_init, 1);
        check("rx_enable0",   uart_en, 0);
        check("rx_owner",     owner, 1);
        check("rx_vga_en",    vga_en, 0);
        check("rx_busy",      busy, 1);
        step(1);
        check("rx_init_off",  uart_init, 0);
        check("rx_enable1",   uart_en, 1);
        step(1);
        check("rx_enable_off", uart_en, 0);
        check("rx_mux_addr",  bus.sram_address, 32'h00055);
        check("rx_mux_data",  bus.sram_write_data, 32'h1111);

        // UART writes every 100 cycles; start bits are ignored meanwhile
        for (int i = 0; i < 3; i++) begin
            uart_we_n = 1'b0;
            #1;
            check("rx_mux_we", bus.sram_we_n, 0);
            step(1);
            uart_we_n = 1'b1;
            uart_rx   = (i == 1) ? 1'b0 : 1'b1;
            step(99);
        end
        uart_rx = 1'b1;

        // Last write edge T, then a write exactly on the would-be expiry cycle
        uart_we_n = 1'b0;
        step(1);
        uart_we_n = 1'b1;
        step(1000);
        check("rx_timer_full", owner, 1);
        uart_we_n = 1'b0;
        step(1);
        uart_we_n = 1'b1;
        check("rx_write_wins", owner, 1);
        step(1000);
        check("rx_before_exp", owner, 1);
        m1_we_n = 1'b0;
        step(1);
        check("gA_owner",     owner, 3);
        check("gA_busy",      busy, 1);
        check("gA_we_n",      bus.sram_we_n, 1);
        check("gA_addr",      bus.sram_address, 0);
        check("gA_wdata",     bus.sram_write_data, 0);
        check("gA_m1_start",  m1_start, 0);
        step(1);
        check("gA2_owner",    owner, 3);
        check("gA2_m1_start", m1_start, 0);
        step(1);
        check("m1s_owner",    owner, 2);
        check("m1s_start",    m1_start, 1);

        // m1_done during S_M1_START is ignored
        m1_done = 1'b1;
        step(1);
        m1_done = 1'b0;
        check("m1r_start_off", m1_start, 0);
        check("m1r_owner",     owner, 2);
        check("m1r_addr",      bus.sram_address, 32'h1234);
        check("m1r_wdata",     bus.sram_write_data, 32'hBEEF);
        check("m1r_we_n",      bus.sram_we_n, 0);
        for (int i = 0; i < 4; i++) begin
            uart_rx = i[0];
            step(1);
        end
        uart_rx = 1'b1;
        check("m1r_no_preempt", owner, 2);
        check("m1r_busy",       busy, 1);

        m1_done = 1'b1;
        step(1);
        m1_done = 1'b0;
        check("gB_owner",  owner, 3);
        check("gB_we_n",   bus.sram_we_n, 1);
        check("gB_vga_en", vga_en, 0);
        step(1);
        check("gB2_owner", owner, 3);
        check("gB2_we_n",  bus.sram_we_n, 1);
        step(1);
        check("dsp_owner",  owner, 0);
        check("dsp_vga_en", vga_en, 1);
        check("dsp_busy",   busy, 0);
        check("dsp_addr",   bus.sram_address, 32'h2AAAA);
        check("dsp_we_n",   bus.sram_we_n, 1);
        step(3);
        check("dsp_stay", owner, 0);

        // Re-entry from S_DISPLAY: fresh pulse pair and timer restarted from 0
        uart_rx = 1'b0;
        step(1);
        uart_rx = 1'b1;
        check("re_init",  uart_init, 1);
        check("re_owner", owner, 1);
        check("re_vga",   vga_en, 0);
        step(1);
        check("re_enable", uart_en, 1);
        step(1);
        check("re_enable_off", uart_en, 0);
        step(998);
        check("re_before_exp", owner, 1);
        step(1);
        check("re_expired", owner, 3);
        step(2);
        check("re_m1_start", m1_start, 1);
        step(5);
        check("re_m1_run", owner, 2);
        check("re_m1_we",  bus.sram_we_n, 0);

        // Asynchronous reset mid-M1 pass
        #3;
        resetn = 1'b0;
        #1;
        check("arst_we_n",   bus.sram_we_n, 1);
        check("arst_owner",  owner, 0);
        check("arst_vga_en", vga_en, 1);
        check("arst_busy",   busy, 0);
        check("arst_addr",   bus.sram_address, 32'h2AAAA);
        step(1);
        resetn = 1'b1;
        step(2);
        check("post_rst_idle", busy, 0);
        check("post_rst_own",  owner, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
